iter_alu_exec: RTL

//  Execute-stage consumer of the decoder's alu_op_e stream (types package).
//  - Accepts one operation per valid/ready handshake; holds each result until downstream takes it.
//  - Non-shift ops take 1 cycle; shifts run iteratively, 1 bit per cycle (or 1 cycle with fast shift).
//  - Sits between the decode/operand-select stage and writeback.

---
 rtl/iter_alu_exec_if.sv | 23 ++
 rtl/iter_alu_exec.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/iter_alu_exec_if.sv
// Handshake bus for iter_alu_exec: operand request channel plus result channel.
interface iter_alu_exec_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_illegal
  );
endinterface

// File: rtl/iter_alu_exec.sv
// Execute-stage ALU: single-cycle ops, iterative 1-bit/cycle shifter by default.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a barrel shifter.
module iter_alu_exec #(
  parameter int XLEN = 32
) (
  input logic            clk,
  input logic            rst_n,
  iter_alu_exec_if.slave bus
);
  localparam int SW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND    = 4'd2,  OP_OR     = 4'd3,
    OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL    = 4'd6,  OP_SRA    = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_A_PASS = 4'd10, OP_B_PASS = 4'd11,
    OP_NOP  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e          state;
  alu_op_e         op;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] res;
  logic            illegal;

  assign op           = alu_op_e'(bus.in_op);
  assign shamt        = bus.in_b[SW-1:0];
  // Gated by rst_n so the block never advertises ready while held in reset.
  assign bus.in_ready = rst_n && (state == S_IDLE);

`ifdef ALU_FAST_SHIFT_EN
`else
  alu_op_e         op_q;
  logic [XLEN-1:0] work;
  logic [XLEN-1:0] step;
  logic [SW-1:0]   cnt;
  logic            is_shift;

  always_comb begin
    step = {1'b0, work[XLEN-1:1]};
    case (op_q)
      OP_SLL:  step = {work[XLEN-2:0], 1'b0};
      OP_SRA:  step = {work[XLEN-1], work[XLEN-1:1]};
      default: step = {1'b0, work[XLEN-1:1]};
    endcase
  end
`endif

  always_comb begin
    res     = '0;
    illegal = 1'b0;
`ifdef ALU_FAST_SHIFT_EN
`else
    is_shift = 1'b0;
`endif
    case (op)
      OP_ADD:    res = bus.in_a + bus.in_b;
      OP_SUB:    res = bus.in_a - bus.in_b;
      OP_AND:    res = bus.in_a & bus.in_b;
      OP_OR:     res = bus.in_a | bus.in_b;
      OP_XOR:    res = bus.in_a ^ bus.in_b;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:    res = bus.in_a << shamt;
      OP_SRL:    res = bus.in_a >> shamt;
      OP_SRA:    res = $unsigned($signed(bus.in_a) >>> shamt);
`else
      // Zero-distance shifts finish immediately; others go through SHIFT.
      OP_SLL, OP_SRL, OP_SRA: begin
        res      = bus.in_a;
        is_shift = 1'b1;
      end
`endif
      OP_SLT:    res = {{(XLEN-1){1'b0}}, $signed(bus.in_a) < $signed(bus.in_b)};
      OP_SLTU:   res = {{(XLEN-1){1'b0}}, bus.in_a < bus.in_b};
      OP_A_PASS: res = bus.in_a;
      OP_B_PASS: res = bus.in_b;
      OP_NOP:    res = '0;
      default:   illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      bus.out_valid   <= 1'b0;
      bus.out_result  <= '0;
      bus.out_zero    <= 1'b0;
      bus.out_illegal <= 1'b0;
`ifdef ALU_FAST_SHIFT_EN
`else
      op_q <= OP_NOP;
      work <= '0;
      cnt  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            bus.out_illegal <= illegal;
            if (op != OP_NOP) begin
`ifdef ALU_FAST_SHIFT_EN
              bus.out_result <= res;
              bus.out_zero   <= (res == '0);
              bus.out_valid  <= 1'b1;
              state          <= S_DONE;
`else
              if (is_shift && shamt != '0) begin
                op_q  <= op;
                work  <= bus.in_a;
                cnt   <= shamt;
                state <= S_SHIFT;
              end else begin
                bus.out_result <= res;
                bus.out_zero   <= (res == '0);
                bus.out_valid  <= 1'b1;
                state          <= S_DONE;
              end
`endif
            end
          end
        end
`ifdef ALU_FAST_SHIFT_EN
`else
        S_SHIFT: begin
          work <= step;
          cnt  <= cnt - 1'b1;
          if (cnt == SW'(1)) begin
            bus.out_result <= step;
            bus.out_zero   <= (step == '0);
            bus.out_valid  <= 1'b1;
            state          <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
